// File: rtl/alu_pkg.sv
// Shared opcode constants, issue FSM state type and default datapath sizing.
// Imported by the issue controller and its register file.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int NREGS_DEF  = 16;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_DIV  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_ZERO = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Architectural register file: two combinational read ports, one synchronous write port.
// Synchronous reset clears every entry; reset wins over a same-cycle write.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  i_raddr1,
    output logic [DATA_W-1:0] o_rdata1,
    input  logic [IDX_W-1:0]  i_raddr2,
    output logic [DATA_W-1:0] o_rdata2,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    logic [DATA_W-1:0] r_mem [NREGS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = r_mem[i_raddr1];
    assign o_rdata2 = r_mem[i_raddr2];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue FSM for an external ALU: wb_valid 4 cycles after accept for ALU ops, 2 for loads; in_ready only in IDLE.
// ALU_ISSUE_DIVZERO_TRAP_EN adds a sticky div_err and aborts divides by zero before EXEC.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_ld,
    input  logic [DATA_W-1:0] in_imm,
    input  logic [IDX_W-1:0]  in_rd,
    input  logic [IDX_W-1:0]  in_rs1,
    input  logic [IDX_W-1:0]  in_rs2,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_res,
    input  logic              alu_zero,
    output logic              wb_valid,
    output logic [IDX_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              zero_flag
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    ,
    output logic              div_err
`endif
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_read;
    logic              w_exec;
    logic              w_wb;

    logic [2:0]        r_op;
    logic              r_ld;
    logic [DATA_W-1:0] r_imm;
    logic [IDX_W-1:0]  r_rd;
    logic [IDX_W-1:0]  r_rs1;
    logic [IDX_W-1:0]  r_rs2;
    logic [DATA_W-1:0] r_alu_a;
    logic [DATA_W-1:0] r_alu_b;
    logic [2:0]        r_alu_sel;
    logic [DATA_W-1:0] r_res;
    logic              r_zero_cap;
    logic              r_wb_valid;
    logic [IDX_W-1:0]  r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;
    logic              r_zero_flag;

    logic [DATA_W-1:0] w_rdata1;
    logic [DATA_W-1:0] w_rdata2;
    logic [DATA_W-1:0] w_wb_data;

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    logic              w_trap;
    logic              r_div_err;
`endif

    alu_regfile #(
        .NREGS  (NREGS),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .i_raddr1 (r_rs1),
        .o_rdata1 (w_rdata1),
        .i_raddr2 (r_rs2),
        .o_rdata2 (w_rdata2),
        .i_we     (w_wb),
        .i_waddr  (r_rd),
        .i_wdata  (w_wb_data)
    );

    assign w_wb_data = r_ld ? r_imm : r_res;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_read   = 1'b0;
        w_exec   = 1'b0;
        w_wb     = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
        w_trap   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = in_ld ? ST_WB : ST_READ;
                end
            end
            ST_READ: begin
                w_read = 1'b1;
                w_next = ST_EXEC;
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
                if (r_op == OP_DIV && w_rdata2 == '0) begin
                    w_trap = 1'b1;
                    w_next = ST_IDLE;
                end
`endif
            end
            ST_EXEC: begin
                w_exec = 1'b1;
                w_next = ST_WB;
            end
            ST_WB: begin
                w_wb   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // wb_* are registered, so the pulse lands in the IDLE cycle right after the regfile write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op        <= '0;
            r_ld        <= 1'b0;
            r_imm       <= '0;
            r_rd        <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= '0;
            r_res       <= '0;
            r_zero_cap  <= 1'b0;
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= '0;
            r_wb_data   <= '0;
            r_zero_flag <= 1'b0;
        end else begin
            r_wb_valid <= w_wb;
            if (w_accept) begin
                r_op  <= in_op;
                r_ld  <= in_ld;
                r_imm <= in_imm;
                r_rd  <= in_rd;
                r_rs1 <= in_rs1;
                r_rs2 <= in_rs2;
            end
            if (w_read) begin
                r_alu_a   <= w_rdata1;
                r_alu_b   <= w_rdata2;
                r_alu_sel <= r_op;
            end
            if (w_exec) begin
                r_res      <= alu_res;
                r_zero_cap <= alu_zero;
            end
            if (w_wb) begin
                r_wb_rd   <= r_rd;
                r_wb_data <= w_wb_data;
                if (!r_ld) begin
                    r_zero_flag <= r_zero_cap;
                end
            end
        end
    end

`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_err <= 1'b0;
        end else if (w_trap) begin
            r_div_err <= 1'b1;
        end
    end

    assign div_err = r_div_err;
`endif

    assign in_ready  = (r_state == ST_IDLE);
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_sel   = r_alu_sel;
    assign wb_valid  = r_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign zero_flag = r_zero_flag;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus random instructions
// compared against an architectural register-array model and a behavioural ALU.
module tb_alu_issue_ctrl;
    import alu_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_op;
    logic       in_ld;
    logic [7:0] in_imm;
    logic [3:0] in_rd;
    logic [3:0] in_rs1;
    logic [3:0] in_rs2;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_res;
    logic       alu_zero;
    logic       wb_valid;
    logic [3:0] wb_rd;
    logic [7:0] wb_data;
    logic       zero_flag;
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
    logic       div_err;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] ref_regs [16];
    logic       ref_zero;
    logic       ref_derr;

    alu_issue_ctrl #(.NREGS(16), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_ld     (in_ld),
        .in_imm    (in_imm),
        .in_rd     (in_rd),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_res   (alu_res),
        .alu_zero  (alu_zero),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .zero_flag (zero_flag)
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
        ,
        .div_err   (div_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: results wrap to 8 bits; divide by zero returns all ones.
    function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return p[7:0];
            3'd3:    return (b == 8'd0) ? 8'hFF : a / b;
            3'd4:    return a & b;
            3'd5:    return a | b;
            3'd6:    return ~(a & b);
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res  = alu_fn(alu_sel, alu_a, alu_b);
    assign alu_zero = (alu_res == 8'h00);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) ref_regs[i] = 8'h00;
        ref_zero = 1'b0;
        ref_derr = 1'b0;
    endtask

    // Issue one instruction from a negedge, then watch 8 cycles and score it.
    task automatic issue(input logic ld, input logic [2:0] op, input logic [7:0] imm,
                         input logic [3:0] rd, input logic [3:0] rs1, input logic [3:0] rs2);
        logic [7:0] a, b, res, wdat;
        logic [3:0] wrd;
        logic       trap, wz;
        int         got, pulses, lows, exp_s, w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("rdy_wait", 32'(in_ready), 32'd1);
        a     = ref_regs[rs1];
        b     = ref_regs[rs2];
        res   = ld ? imm : alu_fn(op, a, b);
        trap  = 1'b0;
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
        trap  = !ld && (op == OP_DIV) && (b == 8'h00);
`endif
        exp_s = ld ? 2 : 4;
        in_ld = ld; in_op = op; in_imm = imm; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_valid = 1'b1;
        @(posedge clk);
        got = 0; pulses = 0; lows = 0; wdat = 8'h00; wrd = 4'h0; wz = 1'b0;
        for (int s = 1; s <= 8; s++) begin
            @(negedge clk);
            if (s == 1) in_valid = 1'b0;
            if (!in_ready) lows++;
            if (!ld && !trap && (s == 2 || s == 4)) begin
                chk("alu_a", 32'(alu_a), 32'(a));
                chk("alu_b", 32'(alu_b), 32'(b));
                chk("alu_sel", 32'(alu_sel), 32'(op));
            end
            if (wb_valid) begin
                pulses++;
                if (got == 0) begin
                    got = s; wdat = wb_data; wrd = wb_rd; wz = zero_flag;
                end
            end
        end
        if (trap) begin
            ref_derr = 1'b1;
            chk("trap_wb_pulses", 32'(pulses), 32'd0);
            chk("trap_rdy_low", 32'(lows), 32'd1);
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
            chk("div_err", 32'(div_err), 32'(ref_derr));
`endif
        end else begin
            if (!ld) ref_zero = (res == 8'h00);
            chk("wb_latency", 32'(got), 32'(exp_s));
            chk("wb_pulses", 32'(pulses), 32'd1);
            chk("rdy_low", 32'(lows), 32'(exp_s - 1));
            chk("wb_rd", 32'(wrd), 32'(rd));
            chk("wb_data", 32'(wdat), 32'(res));
            chk("zero_flag", 32'(wz), 32'(ref_zero));
            ref_regs[rd] = res;
        end
    endtask

    initial begin
        logic [7:0] q [$];
        logic [7:0] r;
        int acc, wbs, low, n;

        rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_ld = 1'b0; in_imm = 8'h00;
        in_rd = 4'd0; in_rs1 = 4'd0; in_rs2 = 4'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_zero_flag", 32'(zero_flag), 32'd0);
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
`ifdef ALU_ISSUE_DIVZERO_TRAP_EN
        chk("rst_div_err", 32'(div_err), 32'd0);
`endif

        issue(1'b0, OP_ADD, 8'h00, 4'd3, 4'd1, 4'd2);
        issue(1'b1, OP_ADD, 8'hC8, 4'd1, 4'd0, 4'd0);
        issue(1'b1, OP_ADD, 8'h64, 4'd2, 4'd0, 4'd0);
        issue(1'b0, OP_ADD, 8'h00, 4'd3, 4'd1, 4'd2);
        issue(1'b1, OP_ADD, 8'h0F, 4'd4, 4'd0, 4'd0);
        issue(1'b0, OP_SUB, 8'h00, 4'd4, 4'd4, 4'd4);
        issue(1'b1, OP_ADD, 8'h5A, 4'd6, 4'd0, 4'd0);
        issue(1'b0, OP_OR,  8'h00, 4'd5, 4'd4, 4'd6);
        issue(1'b0, OP_MUL, 8'h00, 4'd7, 4'd1, 4'd2);
        issue(1'b0, OP_NAND, 8'h00, 4'd1, 4'd1, 4'd6);

        // Reset while the ALU op sits in EXEC: nothing may be written back.
        issue(1'b1, OP_ADD, 8'h05, 4'd1, 4'd0, 4'd0);
        issue(1'b1, OP_ADD, 8'h07, 4'd2, 4'd0, 4'd0);
        in_ld = 1'b0; in_op = OP_ADD; in_rd = 4'd3; in_rs1 = 4'd1; in_rs2 = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        n = 0;
        for (int s = 0; s < 6; s++) begin
            if (wb_valid) n++;
            @(negedge clk);
        end
        chk("rst_exec_wb_pulses", 32'(n), 32'd0);
        chk("rst_exec_zero_flag", 32'(zero_flag), 32'd0);
        issue(1'b0, OP_OR, 8'h00, 4'd8, 4'd3, 4'd3);

        issue(1'b1, OP_ADD, 8'h37, 4'd1, 4'd0, 4'd0);
        issue(1'b0, OP_DIV, 8'h00, 4'd5, 4'd1, 4'd0);
        issue(1'b0, OP_ADD, 8'h00, 4'd9, 4'd5, 4'd0);

        for (int i = 0; i < 60; i++) begin
            issue(($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // in_valid held high across back-to-back ALU instructions.
        acc = 0; wbs = 0; low = 0;
        in_ld = 1'b0; in_op = 3'($urandom_range(0, 7)); if (in_op == OP_DIV) in_op = OP_MUL;
        in_rd = 4'($urandom_range(0, 15)); in_rs1 = 4'($urandom_range(0, 15)); in_rs2 = 4'($urandom_range(0, 15));
        in_valid = 1'b1;
        for (int c = 0; c < 200 && (acc < 8 || q.size() > 0); c++) begin
            if (wb_valid) begin
                wbs++;
                if (q.size() > 0) chk("strm_wb_data", 32'(wb_data), 32'(q.pop_front()));
                else chk("strm_extra_wb", 32'(wbs), 32'd8);
            end
            if (in_ready && in_valid) begin
                if (acc > 0) chk("strm_rdy_low", 32'(low), 32'd3);
                r = alu_fn(in_op, ref_regs[in_rs1], ref_regs[in_rs2]);
                q.push_back(r);
                ref_regs[in_rd] = r;
                ref_zero = (r == 8'h00);
                acc++;
                low = 0;
            end else if (!in_ready) begin
                low++;
                if (low == 1) begin
                    if (acc < 8) begin
                        in_op = 3'($urandom_range(0, 7)); if (in_op == OP_DIV) in_op = OP_ADD;
                        in_rd = 4'($urandom_range(0, 15));
                        in_rs1 = 4'($urandom_range(0, 15)); in_rs2 = 4'($urandom_range(0, 15));
                    end else begin
                        in_valid = 1'b0;
                    end
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("strm_accepts", 32'(acc), 32'd8);
        chk("strm_wb_count", 32'(wbs), 32'd8);
        chk("strm_zero_flag", 32'(zero_flag), 32'(ref_zero));
        issue(1'b0, OP_OR, 8'h00, 4'd10, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter: NREGS, 16, number of 8-bit architectural registers (power of two, index width log2(NREGS)).
REQ-002 Parameter: DATA_W, 8, operand/result width; matches the ALU datapath.
REQ-003 Clock and reset are fixed: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock for all state.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: in_valid  input  1  instruction offered.
REQ-007 Port: in_ready  output  1  block can accept an instruction; high only in IDLE.
REQ-008 Port: in_op  input  3  ALU select code: 000 add, 001 sub, 010 mul, 011 div, 100 and, 101 or, 110 nand, 111 zero.
REQ-009 Port: in_ld  input  1  load-immediate instruction; bypasses the ALU.
REQ-010 Port: in_imm  input  DATA_W  immediate for in_ld.
REQ-011 Port: in_rd / in_rs1 / in_rs2  input  log2(NREGS) each  destination and source register indices.
REQ-012 Port: alu_a, alu_b  output  DATA_W  registered operands to the ALU.
REQ-013 Port: alu_sel  output  3  registered select to the ALU.
REQ-014 Port: alu_res  input  DATA_W  combinational ALU result.
REQ-015 Port: alu_zero  input  1  ALU zero flag.
REQ-016 Port: wb_valid  output  1  one-cycle pulse when a register is written.
REQ-017 Port: wb_rd, wb_data  output  log2(NREGS), DATA_W  index and value written.
REQ-018 Port: zero_flag  output  1  zero flag of the last completed ALU instruction.
REQ-019 Port: div_err  output  1  sticky divide-by-zero error (present only with the macro).

Function
REQ-020 FSM states: IDLE, READ, EXEC, WB.
REQ-021 IDLE: in_ready=1; on in_valid, latch op/ld/imm/rd/rs1/rs2 and go to READ (ALU op) or WB (in_ld=1).
REQ-022 READ: load alu_a=reg[rs1], alu_b=reg[rs2], alu_sel=op; go to EXEC.
REQ-023 EXEC: capture alu_res and alu_zero into result registers; go to WB.
REQ-024 WB: write the result to reg[rd]; assert wb_valid, wb_rd, wb_data for exactly this cycle; go to IDLE.
REQ-025 Latency: instruction accepted at edge N gives wb_valid high in the cycle after edge N+3 for ALU ops and after edge N+1 for loads.
REQ-026 zero_flag updates only in WB of an ALU op and holds its value through loads.
REQ-027 rs1==rs2, or rd equal to a source, uses the pre-write register values; the write takes effect for the next instruction.
REQ-028 Arithmetic wraps modulo 2^DATA_W as produced by the ALU; no widening.
REQ-029 in_valid outside IDLE is ignored; the instruction stays pending upstream.
REQ-030 alu_a/alu_b/alu_sel hold their values outside READ.

Reset
REQ-031 On rst: state=IDLE; all registers, alu_a, alu_b, alu_sel, wb_rd, wb_data = 0; wb_valid=0; zero_flag=0; div_err=0.
REQ-032 rst mid-instruction abandons it with no register write and no wb_valid.

Configuration
REQ-033 With ALU_ISSUE_DIVZERO_TRAP_EN defined: in READ, op 011 with reg[rs2]==0 sets div_err and returns to IDLE without EXEC/WB; div_err is cleared only by rst.
REQ-034 Without ALU_ISSUE_DIVZERO_TRAP_EN: no div_err port; divide by zero completes normally and writes whatever the ALU returns.

Structure
REQ-035 Shared package alu_pkg holds the opcode constants, the FSM state type, and DATA_W/NREGS defaults.
REQ-036 Register array is a sub-module alu_regfile: 2 combinational read ports, 1 synchronous write port, synchronous reset to 0.

Verification
REQ-037 Reset, then op 000 on r1,r2 -> r3: wb_data=0x00, zero_flag=1.
REQ-038 Load r1=0xC8, r2=0x64, then add -> r3: wb_data=0x2C (wrap), zero_flag=0, wb_valid 4 cycles after accept.
REQ-039 Load r4=0x0F, then sub r4,r4 -> r4: wb_data=0x00, zero_flag=1; next read of r4 returns 0.
REQ-040 in_valid held high continuously: in_ready low for 3 cycles after each accept; exactly one wb_valid per instruction.
REQ-041 rst asserted in EXEC: no wb_valid; r3 reads 0 afterwards.
REQ-042 Macro on: div r1 by r0 (0) -> div_err=1, no wb_valid, r_dest unchanged; macro off: wb_valid pulses.
